ddr_port_arbiter: RTL

// Round-robin arbiter sharing the single avalon_mm_ddr control port between NUM_REQ requesters.

---
 rtl/ddr_port_arbiter_if.sv | 51 +++++
 rtl/ddr_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// ddr_port_arbiter_if
// Bus bundle around the shared avalon_mm_ddr control port.
//   Requester side : req_valid/req_wr/req_addr/req_wdata/req_be (flattened,
//                    slice i = [i*W +: W]) and rsp_done/rsp_err/rsp_rdata.
//   DDR side       : ddr_wr_rq/ddr_rd_rq/ddr_wr_adr/ddr_rd_adr/ddr_wr_data/
//                    ddr_be towards avalon_mm_ddr, ddr_rd_valid/ddr_rd_data/
//                    ddr_done back from it.
// Modports:
//   slave  - the arbiter's view (takes requests, drives the DDR command)
//   master - the surrounding system (requesters plus avalon_mm_ddr)
// ----------------------------------------------------------------------------
interface ddr_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 256,
    parameter int BE_W    = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*BE_W-1:0]   req_be;
    logic [NUM_REQ-1:0]        rsp_done;
    logic [NUM_REQ-1:0]        rsp_err;
    logic [DATA_W-1:0]         rsp_rdata;

    logic                      ddr_wr_rq;
    logic                      ddr_rd_rq;
    logic [ADDR_W-1:0]         ddr_wr_adr;
    logic [ADDR_W-1:0]         ddr_rd_adr;
    logic [DATA_W-1:0]         ddr_wr_data;
    logic [BE_W-1:0]           ddr_be;
    logic                      ddr_rd_valid;
    logic [DATA_W-1:0]         ddr_rd_data;
    logic                      ddr_done;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_be,
        input  ddr_rd_valid, ddr_rd_data, ddr_done,
        output rsp_done, rsp_err, rsp_rdata,
        output ddr_wr_rq, ddr_rd_rq, ddr_wr_adr, ddr_rd_adr, ddr_wr_data, ddr_be
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_be,
        output ddr_rd_valid, ddr_rd_data, ddr_done,
        input  rsp_done, rsp_err, rsp_rdata,
        input  ddr_wr_rq, ddr_rd_rq, ddr_wr_adr, ddr_rd_adr, ddr_wr_data, ddr_be
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_port_arbiter
// Round-robin arbiter sharing the single avalon_mm_ddr control port between
// NUM_REQ requesters (DDR setup loader, packet replay reader, PCI access).
// One requester is granted at a time; its command is latched at grant, issued
// as a one-cycle wr/rd request, and the completion (plus read data) is
// returned to that owner only.
//
// Ports:
//   clk          system clock, everything on posedge
//   rst_n        synchronous reset, active low
//   cal_ok       DDR calibration done (already in clk domain); gates new grants
//   busy         1 from grant up to and including the rsp_done pulse
//   owner        index of current / last owner
//   timeout_err  sticky watchdog flag (0 without DDR_ARB_TIMEOUT_EN)
//   bus          ddr_port_arbiter_if.slave: requester and DDR-side signals
//
// Configuration macro:
//   DDR_ARB_TIMEOUT_EN  enables the WAIT watchdog (TIMEOUT_CYC cycles); when
//                       undefined WAIT waits forever and rsp_err/timeout_err
//                       are tied low.
// ----------------------------------------------------------------------------
module ddr_port_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 256,
    parameter int BE_W        = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cal_ok,
    output logic               busy,
    output logic [2:0]         owner,
    output logic               timeout_err,
    ddr_port_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = IDX_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Elaboration-time guard on the supported configuration range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || BE_W * 8 != DATA_W ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_cfg
        $error("ddr_port_arbiter: unsupported parameter set");
    end

    logic [1:0]          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [2:0]          owner_q;
    logic                busy_q;
    logic                op_wr;
    logic                rd_seen;
    logic                done_seen;
    logic [NUM_REQ-1:0]  rsp_done_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                wr_rq_q;
    logic                rd_rq_q;
    logic [ADDR_W-1:0]   wr_adr_q;
    logic [ADDR_W-1:0]   rd_adr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [BE_W-1:0]     be_q;

    // Arbitration: first pending request at or above rr_ptr, wrapping.
    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    logic [CW-1:0]       cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = CW'(rr_ptr) + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!grant_found && bus.req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    logic                g_wr;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic [BE_W-1:0]     g_be;

    assign g_wr    = bus.req_wr[grant_idx];
    assign g_addr  = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign g_wdata = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
    assign g_be    = bus.req_be[grant_idx*BE_W +: BE_W];

    // A read needs both its data beat and action_done; the sticky flags
    // cover either ordering, and the live inputs cover same-cycle arrival.
    logic rd_hit;
    logic dn_hit;
    logic op_complete;

    assign rd_hit      = rd_seen | bus.ddr_rd_valid;
    assign dn_hit      = done_seen | bus.ddr_done;
    assign op_complete = op_wr ? dn_hit : (rd_hit & dn_hit);

    logic [NUM_REQ-1:0]  owner_onehot;
    logic [IDX_W-1:0]    rr_next;

    assign owner_onehot = NUM_REQ'(1) << owner_q;
    assign rr_next      = (owner_q == 3'(NUM_REQ - 1)) ? '0 : IDX_W'(owner_q + 3'd1);

`ifdef DDR_ARB_TIMEOUT_EN
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYC - 1);

    logic [9:0]          wd_cnt;
    logic [NUM_REQ-1:0]  rsp_err_q;
    logic                tmo_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            op_wr       <= 1'b0;
            rd_seen     <= 1'b0;
            done_seen   <= 1'b0;
            rsp_done_q  <= '0;
            rsp_rdata_q <= '0;
            wr_rq_q     <= 1'b0;
            rd_rq_q     <= 1'b0;
            wr_adr_q    <= '0;
            rd_adr_q    <= '0;
            wr_data_q   <= '0;
            be_q        <= '0;
`ifdef DDR_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            rsp_err_q   <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            wr_rq_q    <= 1'b0;
            rd_rq_q    <= 1'b0;
            rsp_done_q <= '0;
`ifdef DDR_ARB_TIMEOUT_EN
            rsp_err_q  <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (cal_ok && grant_found) begin
                        owner_q   <= 3'(grant_idx);
                        busy_q    <= 1'b1;
                        op_wr     <= g_wr;
                        rd_seen   <= 1'b0;
                        done_seen <= 1'b0;
                        if (g_wr) begin
                            wr_adr_q  <= g_addr;
                            wr_data_q <= g_wdata;
                            be_q      <= g_be;
                        end else begin
                            rd_adr_q  <= g_addr;
                        end
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    wr_rq_q <= op_wr;
                    rd_rq_q <= ~op_wr;
                    if (bus.ddr_done) begin
                        done_seen <= 1'b1;
                    end
                    if (!op_wr && bus.ddr_rd_valid) begin
                        rd_seen     <= 1'b1;
                        rsp_rdata_q <= bus.ddr_rd_data;
                    end
`ifdef DDR_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.ddr_done) begin
                        done_seen <= 1'b1;
                    end
                    if (!op_wr && bus.ddr_rd_valid) begin
                        rd_seen     <= 1'b1;
                        rsp_rdata_q <= bus.ddr_rd_data;
                    end
                    if (op_complete) begin
                        rsp_done_q <= owner_onehot;
                        if (op_wr) begin
                            rsp_rdata_q <= '0;
                        end
                        state <= ST_DONE;
                    end
`ifdef DDR_ARB_TIMEOUT_EN
                    // Completion wins over an expiring watchdog in the same cycle.
                    else if (wd_cnt == WD_LAST) begin
                        rsp_done_q  <= owner_onehot;
                        rsp_err_q   <= owner_onehot;
                        rsp_rdata_q <= '0;
                        tmo_q       <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 10'd1;
                    end
`endif
                end

                ST_DONE: begin
                    busy_q <= 1'b0;
                    rr_ptr <= rr_next;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy            = busy_q;
    assign owner           = owner_q;
    assign bus.rsp_done    = rsp_done_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.ddr_wr_rq   = wr_rq_q;
    assign bus.ddr_rd_rq   = rd_rq_q;
    assign bus.ddr_wr_adr  = wr_adr_q;
    assign bus.ddr_rd_adr  = rd_adr_q;
    assign bus.ddr_wr_data = wr_data_q;
    assign bus.ddr_be      = be_q;

`ifdef DDR_ARB_TIMEOUT_EN
    assign bus.rsp_err     = rsp_err_q;
    assign timeout_err     = tmo_q;
`else
    assign bus.rsp_err     = '0;
    assign timeout_err     = 1'b0;
`endif

endmodule
